sa_skew_feeder: RTL and testbench

Operand sequencer and skew injector for the 4x4 systolic multiply array. It holds one 4x16 A operand and one 16x4 B operand in internal byte buffers. On `start` it clears the array accumulators, then drives A rows onto the array's left-edge inputs and B columns onto its top-edge inputs with the diagonal skew the array needs. When every PE has absorbed its last product, it signals result capture to the result store.

---
 rtl/sa_pkg.sv | 22 ++
 rtl/sa_operand_buf.sv | 39 +++
 rtl/sa_skew_feeder.sv | 141 ++++++++++++++
 tb/tb_sa_skew_feeder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared sizes, FSM states and feed-window helper for the systolic operand feeder
package sa_pkg;

    localparam int N  = 4;
    localparam int K  = 16;
    localparam int DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FEED,
        DONE
    } state_t;

    // Last FEED step: the final product reaches PE(N-1,N-1) at k=K-1, i=j=N-1.
    function automatic int feed_last(input int n, input int k);
        return k + 2 * n - 3;
    endfunction

    localparam int FEED_LAST = feed_last(N, K);

endpackage

// File: rtl/sa_operand_buf.sv
// rtl/sa_operand_buf.sv - R x C byte register file, one write port, one read port per row, async clear
module sa_operand_buf #(
    parameter int R  = 4,
    parameter int C  = 16,
    parameter int DW = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(R)-1:0]          wr_row,
    input  logic [$clog2(C)-1:0]          wr_col,
    input  logic [DW-1:0]                 wr_data,
    input  logic [R-1:0][$clog2(C)-1:0]   rd_col,
    output logic [R-1:0][DW-1:0]          rd_data
);

    logic [DW-1:0] mem [R][C];

    // Byte storage; reset zeroes every entry so a fresh run multiplies zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < R; r++) begin
                for (int c = 0; c < C; c++) begin
                    mem[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Each row has its own read column so the parent can apply a per-row skew.
    always_comb begin
        for (int r = 0; r < R; r++) begin
            rd_data[r] = mem[r][rd_col[r]];
        end
    end

endmodule

// File: rtl/sa_skew_feeder.sv
// rtl/sa_skew_feeder.sv - operand sequencer and diagonal skew injector for the 4x4 systolic array
module sa_skew_feeder #(
    parameter int N  = sa_pkg::N,
    parameter int K  = sa_pkg::K,
    parameter int DW = sa_pkg::DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_valid,
    input  logic                  load_sel,
    input  logic [$clog2(N)-1:0]  load_row,
    input  logic [$clog2(K)-1:0]  load_col,
    input  logic [DW-1:0]         load_data,
    output logic                  load_err,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cap_en,
    output logic                  acc_clr,
    output logic [DW-1:0]         a_row0,
    output logic [DW-1:0]         a_row1,
    output logic [DW-1:0]         a_row2,
    output logic [DW-1:0]         a_row3,
    output logic [DW-1:0]         b_col0,
    output logic [DW-1:0]         b_col1,
    output logic [DW-1:0]         b_col2,
    output logic [DW-1:0]         b_col3
);

    import sa_pkg::*;

    localparam int CW   = $clog2(K);
    localparam int LAST = feed_last(N, K);
    localparam int TW   = $clog2(LAST + 1);

    state_t                 state, nxt_state;
    logic [TW-1:0]          t, nxt_t;
    logic [N-1:0][CW-1:0]   rd_col;
    logic [N-1:0][DW-1:0]   a_rd, b_rd, a_nxt, b_nxt, a_q, b_q;
    logic                   wr_ok;

    // Loads land only while no feed is reading the buffers.
    assign wr_ok = load_valid && (state == IDLE || state == DONE);

    sa_operand_buf #(.R(N), .C(K), .DW(DW)) u_a_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && !load_sel),
        .wr_row  (load_row),
        .wr_col  (load_col),
        .wr_data (load_data),
        .rd_col  (rd_col),
        .rd_data (a_rd)
    );

    // B is stored column-major (row = j, col = k) so it skews exactly like A.
    sa_operand_buf #(.R(N), .C(K), .DW(DW)) u_b_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_ok && load_sel),
        .wr_row  (load_row),
        .wr_col  (load_col),
        .wr_data (load_data),
        .rd_col  (rd_col),
        .rd_data (b_rd)
    );

    // Next state and next feed step.
    always_comb begin
        nxt_state = state;
        nxt_t     = t;
        case (state)
            IDLE:  if (start) nxt_state = CLEAR;
            CLEAR: begin
                nxt_state = FEED;
                nxt_t     = '0;
            end
            FEED: begin
                if (t == TW'(LAST)) begin
                    nxt_state = DONE;
                    nxt_t     = '0;
                end else begin
                    nxt_t = t + 1'b1;
                end
            end
            DONE:  nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Skewed fetch for the coming step: lane i shows index t-i inside the K-wide window, else 0.
    always_comb begin
        rd_col = '0;
        a_nxt  = '0;
        b_nxt  = '0;
        if (nxt_state == FEED) begin
            for (int i = 0; i < N; i++) begin
                if (int'(nxt_t) >= i && int'(nxt_t) - i < K) begin
                    rd_col[i] = CW'(int'(nxt_t) - i);
                    a_nxt[i]  = a_rd[i];
                    b_nxt[i]  = b_rd[i];
                end
            end
        end
    end

    // All outputs come straight from flops, loaded from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            t        <= '0;
            a_q      <= '0;
            b_q      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cap_en   <= 1'b0;
            acc_clr  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= nxt_state;
            t        <= nxt_t;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            busy     <= (nxt_state != IDLE);
            done     <= (nxt_state == DONE);
            cap_en   <= (nxt_state == DONE);
            acc_clr  <= (nxt_state == CLEAR);
            load_err <= load_valid && (state == CLEAR || state == FEED);
        end
    end

    assign a_row0 = a_q[0];
    assign a_row1 = a_q[1];
    assign a_row2 = a_q[2];
    assign a_row3 = a_q[3];
    assign b_col0 = b_q[0];
    assign b_col1 = b_q[1];
    assign b_col2 = b_q[2];
    assign b_col3 = b_q[3];

endmodule

// File: tb/tb_sa_skew_feeder.sv
// tb/tb_sa_skew_feeder.sv - randomized self-checking bench for sa_skew_feeder against an operation-level model
module tb_sa_skew_feeder;

    import sa_pkg::*;

    localparam int LASTT   = FEED_LAST;
    localparam int DONE_PH = K + 2 * N;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_valid, load_sel, start;
    logic [1:0] load_row;
    logic [3:0] load_col;
    logic [7:0] load_data;
    logic       load_err, busy, done, cap_en, acc_clr;
    logic [7:0] a_row0, a_row1, a_row2, a_row3, b_col0, b_col1, b_col2, b_col3;

    always #5 clk = ~clk;

    sa_skew_feeder dut (
        .clk(clk), .rst(rst),
        .load_valid(load_valid), .load_sel(load_sel), .load_row(load_row),
        .load_col(load_col), .load_data(load_data), .load_err(load_err),
        .start(start), .busy(busy), .done(done), .cap_en(cap_en), .acc_clr(acc_clr),
        .a_row0(a_row0), .a_row1(a_row1), .a_row2(a_row2), .a_row3(a_row3),
        .b_col0(b_col0), .b_col1(b_col1), .b_col2(b_col2), .b_col3(b_col3)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: ph = cycles since an accepted start (0 = idle), plus operand matrices.
    int         ph;
    logic       exp_err;
    logic [7:0] A_m [N][K];
    logic [7:0] B_m [K][N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph      = 0;
            exp_err = 1'b0;
            for (int i = 0; i < N; i++)
                for (int k = 0; k < K; k++) begin
                    A_m[i][k] = 8'h00;
                    B_m[k][i] = 8'h00;
                end
        end else begin
            if (load_valid && (ph == 0 || ph == DONE_PH)) begin
                if (!load_sel) A_m[load_row][load_col] = load_data;
                else           B_m[load_col][load_row] = load_data;
            end
            exp_err = load_valid && ph != 0 && ph != DONE_PH;
            if (ph == 0)            ph = start ? 1 : 0;
            else if (ph == DONE_PH) ph = 0;
            else                    ph = ph + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0]  a_h [N][LASTT+1];
    logic [7:0]  b_h [N][LASTT+1];
    logic [31:0] res [N][N];
    int          res_cnt = 0;
    int          cap_cnt = 0;
    bit          rec_clr = 1'b0;
    int          c0;
    int          clr_q[$];

    // Per-cycle compare against the model; at done, rebuild array results from the observed edges.
    always @(negedge clk) begin
        logic [7:0]  ea [N];
        logic [7:0]  eb [N];
        logic [7:0]  ga [N];
        logic [7:0]  gb [N];
        logic [31:0] acc, ref_c;
        int          t, ta, tb;
        t = ph - 2;
        ga[0] = a_row0; ga[1] = a_row1; ga[2] = a_row2; ga[3] = a_row3;
        gb[0] = b_col0; gb[1] = b_col1; gb[2] = b_col2; gb[3] = b_col3;
        for (int i = 0; i < N; i++) begin
            ea[i] = 8'h00;
            eb[i] = 8'h00;
            if (ph >= 2 && ph < DONE_PH && t - i >= 0 && t - i < K) begin
                ea[i] = A_m[i][t-i];
                eb[i] = B_m[t-i][i];
            end
        end
        check("ctrl{busy,done,cap,clr,err}", {busy, done, cap_en, acc_clr, load_err},
              {ph != 0, ph == DONE_PH, ph == DONE_PH, ph == 1, exp_err});
        check("feed{a3..a0,b3..b0}", {ga[3], ga[2], ga[1], ga[0], gb[3], gb[2], gb[1], gb[0]},
              {ea[3], ea[2], ea[1], ea[0], eb[3], eb[2], eb[1], eb[0]});
        if (ph >= 2 && ph < DONE_PH)
            for (int i = 0; i < N; i++) begin
                a_h[i][t] = ga[i];
                b_h[i][t] = gb[i];
            end
        if (cap_en) cap_cnt++;
        if (rec_clr && acc_clr) clr_q.push_back(cyc - c0);
        if (ph == DONE_PH) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    acc = 32'd0;
                    for (int s = 0; s <= LASTT; s++) begin
                        ta = s - j;
                        tb = s - i;
                        if (ta >= 0 && tb >= 0) acc += 32'(a_h[i][ta]) * 32'(b_h[j][tb]);
                    end
                    ref_c = 32'd0;
                    for (int k = 0; k < K; k++) ref_c += 32'(A_m[i][k]) * 32'(B_m[k][j]);
                    res[i][j] = acc;
                    check("array_result", acc, ref_c);
                end
            res_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_byte(input logic sel, input int row, input int col, input logic [7:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_row   = 2'(row);
        load_col   = 4'(col);
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_rand();
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                load_byte(1'b0, i, k, 8'($urandom));
                load_byte(1'b1, i, k, 8'($urandom));
            end
    endtask

    task automatic run_op();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (DONE_PH) tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    logic [31:0] r1 [N][N];
    int          nbad, cap0;

    initial begin
        rst = 1'b1; load_valid = 1'b0; load_sel = 1'b0; load_row = '0;
        load_col = '0; load_data = '0; start = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {busy, done, cap_en, acc_clr, load_err, a_row0, a_row1, a_row2,
              a_row3, b_col0, b_col1, b_col2, b_col3}, 64'd0);
        rst = 1'b0;
        tick();

        // Identity A, B all 2.
        for (int i = 0; i < N; i++) load_byte(1'b0, i, i, 8'd1);
        for (int j = 0; j < N; j++)
            for (int k = 0; k < K; k++) load_byte(1'b1, j, k, 8'd2);
        cap0 = cap_cnt;
        run_op();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check("identity_c", res[i][j], 32'd2);
        check("identity_cap_count", cap_cnt - cap0, 1);

        // Full-range product.
        for (int i = 0; i < N; i++)
            for (int k = 0; k < K; k++) begin
                load_byte(1'b0, i, k, 8'hFF);
                load_byte(1'b1, i, k, 8'hFF);
            end
        run_op();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) check("fullrange_c", res[i][j], 32'd1040400);
        nbad = 0;
        for (int t = 0; t <= LASTT; t++)
            if ((a_h[3][t] != 8'h00) != (t >= 3 && t <= 18)) nbad++;
        check("a_row3_window", nbad, 0);

        // Single-byte skew.
        pulse_rst();
        load_byte(1'b0, 2, 0, 8'd7);
        run_op();
        check("skew_a2_t2", a_h[2][2], 8'd7);
        nbad = 0;
        for (int i = 0; i < N; i++)
            for (int t = 0; t <= LASTT; t++)
                if (!(i == 2 && t == 2) && a_h[i][t] != 8'h00) nbad++;
        check("skew_others_zero", nbad, 0);

        // Load while busy is dropped and flagged.
        load_rand();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        load_valid = 1'b1; load_sel = 1'b0; load_row = 2'd1; load_col = 4'd3; load_data = 8'h55;
        tick();
        load_valid = 1'b0;
        check("busy_load_err", load_err, 1'b1);
        tick();
        check("busy_load_err_pulse", load_err, 1'b0);
        repeat (15) tick();
        r1 = res;
        run_op();
        nbad = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) if (res[i][j] !== r1[i][j]) nbad++;
        check("repeat_same", nbad, 0);

        // Back-to-back with start held.
        c0 = cyc;
        rec_clr = 1'b1;
        start = 1'b1;
        repeat (75) tick();
        start = 1'b0;
        rec_clr = 1'b0;
        check("b2b_clr_count", clr_q.size(), 3);
        if (clr_q.size() == 3) begin
            check("b2b_clr0", clr_q[0], 1);
            check("b2b_clr1", clr_q[1], 26);
            check("b2b_clr2", clr_q[2], 51);
        end
        tick();

        // Reset at FEED t=10.
        load_rand();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (11) tick();
        cap0 = cap_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_outputs", {busy, done, cap_en, acc_clr, load_err, a_row0, a_row1, a_row2,
              a_row3, b_col0, b_col1, b_col2, b_col3}, 64'd0);
        tick();
        rst = 1'b0;
        repeat (30) tick();
        check("rst_mid_no_done", cap_cnt - cap0, 0);
        load_rand();
        run_op();

        // Random traffic: loads, starts and busy loads mixed.
        for (int n = 0; n < 300; n++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_sel   = 1'($urandom);
            load_row   = 2'($urandom);
            load_col   = 4'($urandom);
            load_data  = 8'($urandom);
            start      = ($urandom_range(0, 7) == 0);
            tick();
        end
        load_valid = 1'b0;
        start = 1'b0;
        repeat (30) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
